// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, oversampled SCL/SDA, open-drain SDA, no clock stretching.
// Define I2C_SLAVE_FILT_EN to add a FILT_LEN-sample glitch filter on the synced bus lines.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h0D,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       din_req,
    output logic       rd_wr,
    output logic       busy,
    output logic       nack_rx
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_s, sda_s;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       ack_seen_q, ack_seen_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       din_req_q, din_req_d;
    logic       rd_wr_q, rd_wr_d;
    logic       busy_q, busy_d;
    logic       nack_rx_q, nack_rx_d;

    // Two-flop synchronizers; idle bus level is high.
    always_comb begin
        scl_sync_d = {scl_sync_q[0], SCL};
        sda_sync_d = {sda_sync_q[0], SDA};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_SLAVE_FILT_EN
    localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [FCW-1:0] scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
    logic           scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    // A line changes only after FILT_LEN consecutive samples disagree with the held value.
    always_comb begin
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        scl_fcnt_d = '0;
        sda_fcnt_d = '0;
        if (scl_sync_q[1] != scl_filt_q) begin
            if (scl_fcnt_q == FCW'(FILT_LEN - 1)) scl_filt_d = scl_sync_q[1];
            else                                  scl_fcnt_d = scl_fcnt_q + FCW'(1);
        end
        if (sda_sync_q[1] != sda_filt_q) begin
            if (sda_fcnt_q == FCW'(FILT_LEN - 1)) sda_filt_d = sda_sync_q[1];
            else                                  sda_fcnt_d = sda_fcnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_fcnt_q <= '0;
            sda_fcnt_q <= '0;
        end else begin
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
            scl_fcnt_q <= scl_fcnt_d;
            sda_fcnt_q <= sda_fcnt_d;
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    // FILT_LEN only matters when the glitch filter is built in.
    if (FILT_LEN == 0) begin : g_no_filter
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_comb begin
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

    // Next-state and registered-output logic; START/STOP win over every state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sda_oe_d     = sda_oe_q;
        ack_seen_d   = ack_seen_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        din_req_d    = 1'b0;
        nack_rx_d    = 1'b0;
        rd_wr_d      = rd_wr_q;
        busy_d       = busy_q;

        if (start_det) begin
            state_d    = ADDR;
            bit_cnt_d  = 3'd0;
            busy_d     = 1'b1;
            sda_oe_d   = 1'b0;
            ack_seen_d = 1'b0;
        end else if (stop_det) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == SLAVE_ADDR) begin
                                rd_wr_d = sda_s;
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                // First fall drives the ACK low, the second releases it and moves on.
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (state_q == RX_ACK || !rd_wr_q) begin
                            sda_oe_d = 1'b0;
                            state_d  = RX;
                        end else begin
                            shift_d   = din[6:0];
                            sda_oe_d  = ~din[7];
                            din_req_d = 1'b1;
                            bit_cnt_d = 3'd0;
                            state_d   = TX;
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            dout_d       = {shift_q, sda_s};
                            dout_valid_d = 1'b1;
                            state_d      = RX_ACK;
                        end
                    end
                end
                // shift_q holds the bits still to send, next one in bit 6.
                TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d   = 1'b0;
                            bit_cnt_d  = 3'd0;
                            ack_seen_d = 1'b0;
                            state_d    = TX_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_seen_d = 1'b1;
                        end else begin
                            nack_rx_d = 1'b1;
                            sda_oe_d  = 1'b0;
                            state_d   = IGNORE;
                        end
                    end else if (scl_fall && ack_seen_q) begin
                        shift_d    = din[6:0];
                        sda_oe_d   = ~din[7];
                        din_req_d  = 1'b1;
                        bit_cnt_d  = 3'd0;
                        ack_seen_d = 1'b0;
                        state_d    = TX;
                    end
                end
                IDLE, IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            sda_oe_q     <= 1'b0;
            ack_seen_q   <= 1'b0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            din_req_q    <= 1'b0;
            nack_rx_q    <= 1'b0;
            rd_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sda_oe_q     <= sda_oe_d;
            ack_seen_q   <= ack_seen_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            din_req_q    <= din_req_d;
            nack_rx_q    <= nack_rx_d;
            rd_wr_q      <= rd_wr_d;
            busy_q       <= busy_d;
        end
    end

    assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign din_req    = din_req_q;
    assign rd_wr      = rd_wr_q;
    assign busy       = busy_q;
    assign nack_rx    = nack_rx_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a behavioural bus master plus pulse monitors, checked against
// expectations derived from the I2C transaction rules (address match, ACK/NACK, byte order).
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int          HALF = 100;   // SCL half period in ns (10 clk)
    localparam logic [6:0]  MY_ADDR = 7'h0D;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_low;
    logic [7:0] din;
    wire        sda_bus;
    logic [7:0] dout;
    logic       dout_valid, din_req, rd_wr, busy, nack_rx;

    int total = 0;
    int bad   = 0;

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk        (clk),
        .reset      (reset),
        .SCL        (scl),
        .SDA        (sda_bus),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .din_req    (din_req),
        .rd_wr      (rd_wr),
        .busy       (busy),
        .nack_rx    (nack_rx)
    );

    // Free-running event counters, sampled away from the active edge.
    int         dv_cnt = 0, rq_cnt = 0, nk_cnt = 0, pull_cnt = 0, busy_cnt = 0;
    logic [7:0] dv_log [0:255];

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            dv_log[dv_cnt[7:0]] = dout;
            dv_cnt++;
        end
        if (din_req === 1'b1) rq_cnt++;
        if (nack_rx === 1'b1) nk_cnt++;
        if (sda_bus === 1'b0 && !sda_low) pull_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    // ---------------- master bus primitives ----------------
    task automatic bus_start();
        if (scl == 1'b0) begin
            #(HALF/2); sda_low = 1'b0;
            #(HALF/2); scl = 1'b1;
            #(HALF/2);
        end else begin
            sda_low = 1'b0;
            #HALF;
        end
        sda_low = 1'b1;
        #HALF; scl = 1'b0;
    endtask

    task automatic bus_stop();
        #(HALF/2); sda_low = 1'b1;
        #(HALF/2); scl = 1'b1;
        #HALF;     sda_low = 1'b0;
        #HALF;
    endtask

    task automatic write_bit(input logic b);
        #(HALF/2); sda_low = !b;
        #(HALF/2); scl = 1'b1;
        #HALF;     scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        #(HALF/2); sda_low = 1'b0;
        #(HALF/2); scl = 1'b1;
        #(HALF/2); b = sda_bus;
        #(HALF/2); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        for (int i = 7; i >= 0; i--) read_bit(v[i]);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; sda_low = 1'b0; din = 8'h00;
        #10 reset = 1'b0;
        #10;
        total++; if (dout !== 8'h00)       begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (dout_valid !== 1'b0)  begin bad++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        total++; if (din_req !== 1'b0)     begin bad++; $display("FAIL reset_din_req got=%b exp=0", din_req); end
        total++; if (rd_wr !== 1'b0)       begin bad++; $display("FAIL reset_rd_wr got=%b exp=0", rd_wr); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (nack_rx !== 1'b0)     begin bad++; $display("FAIL reset_nack_rx got=%b exp=0", nack_rx); end
        total++; if (sda_bus !== 1'b1)     begin bad++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
        #100;
    endtask

    task automatic test_write();
        logic ack;
        int   dv0 = dv_cnt;
        bus_start();
        send_byte({MY_ADDR, 1'b0}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
        send_byte(8'h12, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_data_ack got=%b exp=0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        bus_stop();
        total++; if (dv_cnt - dv0 != 1) begin bad++; $display("FAIL wr_dv_pulses got=%0d exp=1", dv_cnt - dv0); end
        total++; if (dout !== 8'h12) begin bad++; $display("FAIL wr_dout got=%h exp=12", dout); end
        total++; if (rd_wr !== 1'b0) begin bad++; $display("FAIL wr_rd_wr got=%b exp=0", rd_wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] v;
        int rq0 = rq_cnt, nk0 = nk_cnt;
        din = 8'hA5;
        bus_start();
        send_byte({MY_ADDR, 1'b1}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        recv_byte(v);
        total++; if (v !== 8'hA5) begin bad++; $display("FAIL rd_byte0 got=%h exp=a5", v); end
        din = 8'h3C;
        write_bit(1'b0);
        recv_byte(v);
        total++; if (v !== 8'h3C) begin bad++; $display("FAIL rd_byte1 got=%h exp=3c", v); end
        write_bit(1'b1);
        bus_stop();
        total++; if (rq_cnt - rq0 != 2) begin bad++; $display("FAIL rd_din_req got=%0d exp=2", rq_cnt - rq0); end
        total++; if (nk_cnt - nk0 != 1) begin bad++; $display("FAIL rd_nack got=%0d exp=1", nk_cnt - nk0); end
        total++; if (rd_wr !== 1'b1) begin bad++; $display("FAIL rd_rd_wr got=%b exp=1", rd_wr); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int dv0 = dv_cnt, p0 = pull_cnt;
        bus_start();
        send_byte({7'h0E, 1'b0}, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wa_addr_ack got=%b exp=1", ack); end
        send_byte(8'hFF, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wa_data_ack got=%b exp=1", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wa_busy got=%b exp=1", busy); end
        bus_stop();
        total++; if (pull_cnt != p0) begin bad++; $display("FAIL wa_sda_driven got=%0d exp=0", pull_cnt - p0); end
        total++; if (dv_cnt != dv0) begin bad++; $display("FAIL wa_dout_valid got=%0d exp=0", dv_cnt - dv0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wa_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] v, exp_v;
        int dv0 = dv_cnt;
        bus_start();
        send_byte({MY_ADDR, 1'b0}, ack);
        for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
        exp_v = 8'($urandom);
        din = exp_v;
        bus_start();
        send_byte({MY_ADDR, 1'b1}, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rs_addr_ack got=%b exp=0", ack); end
        total++; if (rd_wr !== 1'b1) begin bad++; $display("FAIL rs_rd_wr got=%b exp=1", rd_wr); end
        recv_byte(v);
        total++; if (v !== exp_v) begin bad++; $display("FAIL rs_byte got=%h exp=%h", v, exp_v); end
        write_bit(1'b1);
        bus_stop();
        total++; if (dv_cnt != dv0) begin bad++; $display("FAIL rs_partial_dropped got=%0d exp=0", dv_cnt - dv0); end
    endtask

    // Random transactions; expectations follow from address match and direction alone.
    task automatic test_random();
        logic [6:0] a;
        logic       rw, match, ack;
        logic [7:0] b, v;
        logic [7:0] exp_q[$];
        int         n, dv0, rq0, nk0, p0;
        for (int t = 0; t < 10; t++) begin
            match = ($urandom_range(0, 3) != 0);
            a     = match ? MY_ADDR : 7'($urandom_range(0, 127));
            if (!match && a == MY_ADDR) a = 7'h55;
            rw  = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 4);
            dv0 = dv_cnt; rq0 = rq_cnt; nk0 = nk_cnt; p0 = pull_cnt;
            exp_q.delete();
            din = 8'($urandom);
            bus_start();
            send_byte({a, rw}, ack);
            total++; if (ack !== !match) begin bad++; $display("FAIL rnd_addr_ack t=%0d got=%b exp=%b", t, ack, !match); end
            if (match && !rw) begin
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_byte(b, ack);
                    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rnd_data_ack t=%0d got=%b exp=0", t, ack); end
                end
            end else if (match) begin
                for (int i = 0; i < n; i++) begin
                    b = din;
                    recv_byte(v);
                    total++; if (v !== b) begin bad++; $display("FAIL rnd_rd_byte t=%0d got=%h exp=%h", t, v, b); end
                    din = 8'($urandom);
                    write_bit(i == n - 1);
                end
            end
            bus_stop();
            if (match && !rw) begin
                total++; if (dv_cnt - dv0 != n) begin bad++; $display("FAIL rnd_dv_cnt t=%0d got=%0d exp=%0d", t, dv_cnt - dv0, n); end
                for (int i = 0; i < n && i < dv_cnt - dv0; i++) begin
                    total++;
                    if (dv_log[8'(dv0 + i)] !== exp_q[i]) begin
                        bad++; $display("FAIL rnd_dout t=%0d i=%0d got=%h exp=%h", t, i, dv_log[8'(dv0 + i)], exp_q[i]);
                    end
                end
            end else if (match) begin
                total++; if (rq_cnt - rq0 != n) begin bad++; $display("FAIL rnd_din_req t=%0d got=%0d exp=%0d", t, rq_cnt - rq0, n); end
                total++; if (nk_cnt - nk0 != 1) begin bad++; $display("FAIL rnd_nack t=%0d got=%0d exp=1", t, nk_cnt - nk0); end
            end else begin
                total++; if (pull_cnt != p0) begin bad++; $display("FAIL rnd_ignored_drive t=%0d got=%0d exp=0", t, pull_cnt - p0); end
            end
            if (match) begin
                total++; if (rd_wr !== rw) begin bad++; $display("FAIL rnd_rd_wr t=%0d got=%b exp=%b", t, rd_wr, rw); end
            end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_busy t=%0d got=%b exp=0", t, busy); end
        end
    endtask

    task automatic test_mid_reset();
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : MY_ADDR[i - 1]);
        #(HALF/2); sda_low = 1'b0;
        #(HALF/2 - 10);
        total++; if (sda_bus !== 1'b0) begin bad++; $display("FAIL mr_ack_driven got=%b exp=0", sda_bus); end
        reset = 1'b1;
        #1;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL mr_sda_release got=%b exp=1", sda_bus); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b exp=0", busy); end
        scl = 1'b1;
        #20 reset = 1'b0;
        #(2*HALF);
    endtask

`ifdef I2C_SLAVE_FILT_EN
    task automatic test_glitch();
        int b0;
        @(negedge clk);
        b0 = busy_cnt;
        sda_low = 1'b1;
        #10 sda_low = 1'b0;
        #(2*HALF);
        total++; if (busy_cnt != b0) begin bad++; $display("FAIL gl_start_seen got=%0d exp=0", busy_cnt - b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gl_busy got=%b exp=0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_repeated_start();
        test_random();
        test_mid_reset();
`ifdef I2C_SLAVE_FILT_EN
        test_glitch();
`endif
        test_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
